// File: rtl/cla16_mp_seq.sv
// Multi-precision add/subtract sequencer: runs a WIDTH-bit operation through one
// shared 16-bit carry-lookahead adder, one segment per cycle, LSB segment first.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        g_out,
  output logic        p_out
);

  // Carries into positions 0..3 of a 4-wide group from generate/propagate terms.
  function automatic logic [3:0] carries4(input logic [3:0] g4, input logic [3:0] p4,
                                          input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g4[0] | (p4[0] & ci);
    c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
    c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & ci);
    return c;
  endfunction

  function automatic logic gen4(input logic [3:0] g4, input logic [3:0] p4);
    return g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0]);
  endfunction

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  cg;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = gen4(g[4*k +: 4], p[4*k +: 4]);
      pg[k] = &p[4*k +: 4];
    end
    cg = carries4(gg, pg, c_in);
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = carries4(g[4*k +: 4], p[4*k +: 4], cg[k]);
    end
    s     = p ^ c;
    g_out = gen4(gg, pg);
    p_out = &pg;
  end

endmodule

module cla16_mp_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int unsigned NSEG  = WIDTH / 16;
  localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        seg;
  logic               seg_g;
  logic               seg_p;
  logic               seg_co;

  cla16 u_cla16 (
    .a     (a_q[15:0]),
    .b     (b_q[15:0]),
    .c_in  (carry),
    .s     (seg),
    .g_out (seg_g),
    .p_out (seg_p)
  );

  assign seg_co = seg_g | (seg_p & carry);
  // New segment enters at the top; after NSEG passes the whole result is aligned.
  assign acc_next = WIDTH'({seg, acc} >> 16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert B now, inject the +1 as carry-in.
            a_q      <= a_in;
            b_q      <= op_sub ? ~b_in : b_in;
            carry    <= op_sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          carry <= seg_co;
          a_q   <= a_q >> 16;
          b_q   <= b_q >> 16;
          acc   <= acc_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NSEG - 1)) begin
            sum       <= acc_next;
            c_out     <= seg_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla16_mp_seq.sv
// Scoreboard bench for cla16_mp_seq: a 64-bit and a 16-bit instance checked against
// an arithmetic reference model, with directed corner cases and random traffic.

module tb_cla16_mp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v64, r64, sub64, ov64, ordy64, c64, busy64;
  logic [63:0] a64, b64, s64;
  logic        v16, r16, sub16, ov16, ordy16, c16, busy16;
  logic [15:0] a16, b16, s16;

  cla16_mp_seq #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .op_sub(sub64),
    .a_in(a64), .b_in(b64), .out_valid(ov64), .out_ready(ordy64), .sum(s64),
    .c_out(c64), .busy(busy64));

  cla16_mp_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .op_sub(sub16),
    .a_in(a16), .b_in(b16), .out_valid(ov16), .out_ready(ordy16), .sum(s16),
    .c_out(c16), .busy(busy16));

  int          nvec = 0;
  int          nerr = 0;
  longint      cyc = 0;
  logic [64:0] q64[$];
  logic [16:0] q16[$];
  int          acc64 = 0;
  int          acc16 = 0;
  longint      edge64 = 0;
  longint      edge16 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: addition with carry out; subtraction with no-borrow flag.
  function automatic logic [64:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                        input logic s);
    if (s) return {(a >= b), 64'(a - b)};
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    if (s) return {(a >= b), 16'(a - b)};
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      2:       return 64'(1) << $urandom_range(0, 63);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      default: return 16'($urandom);
    endcase
  endfunction

  // Acceptance monitors: expected result is queued at the handshake.
  always @(negedge clk) begin
    if (rst_n && v64 && r64) begin
      q64.push_back(ref64(a64, b64, sub64));
      acc64++;
      edge64 = cyc + 1;
    end
    if (rst_n && v16 && r16) begin
      q16.push_back(ref16(a16, b16, sub16));
      acc16++;
      edge16 = cyc + 1;
    end
  end

  logic        hold64 = 1'b0;
  logic        hold16 = 1'b0;
  logic [64:0] held64;
  logic [16:0] held16;

  // Result monitor, 64-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold64 = 1'b0;
    end else begin
      if (hold64) begin
        chk("hold64_valid", 65'(ov64), 65'(1));
        chk("hold64_data", {c64, s64}, held64);
      end
      if (ov64 && !hold64) chk("latency64", 65'(cyc - edge64), 65'(4));
      if (ov64 && ordy64) begin
        if (q64.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL result64: unexpected out_valid, got %h", {c64, s64});
        end else begin
          chk("result64", {c64, s64}, q64.pop_front());
        end
      end
      hold64 = ov64 && !ordy64;
      held64 = {c64, s64};
    end
  end

  // Result monitor, 16-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold16 = 1'b0;
    end else begin
      if (hold16) begin
        chk("hold16_valid", 65'(ov16), 65'(1));
        chk("hold16_data", 65'({c16, s16}), 65'(held16));
      end
      if (ov16 && !hold16) chk("latency16", 65'(cyc - edge16), 65'(1));
      if (ov16 && ordy16) begin
        if (q16.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL result16: unexpected out_valid, got %h", {c16, s16});
        end else begin
          chk("result16", 65'({c16, s16}), 65'(q16.pop_front()));
        end
      end
      hold16 = ov16 && !ordy16;
      held16 = {c16, s16};
    end
  end

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n = 0;
    while (!r64) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("op64_timeout", 65'(r64), 65'(1));
        return;
      end
    end
    v64 = 1'b1; a64 = a; b64 = b; sub64 = s;
    @(posedge clk); #1;
    v64 = 1'b0; a64 = rnd64(); b64 = rnd64(); sub64 = 1'($urandom);
  endtask

  task automatic wait_idle64();
    int n = 0;
    ordy64 = 1'b1;
    while (!(r64 && q64.size() == 0)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("idle64_timeout", 65'(q64.size()), 65'(0));
        return;
      end
    end
  endtask

  task automatic rand64(input int nops);
    int base = acc64;
    int n = 0;
    while (acc64 < base + nops && n < 40000) begin
      @(posedge clk); #1;
      v64 = ($urandom_range(0, 3) != 0);
      a64 = rnd64(); b64 = rnd64(); sub64 = 1'($urandom);
      ordy64 = ($urandom_range(0, 3) != 0);
      n++;
    end
    v64 = 1'b0;
    chk("rand64_count", 65'(acc64 - base), 65'(nops));
    wait_idle64();
  endtask

  task automatic rand16(input int nops);
    int base = acc16;
    int n = 0;
    while (acc16 < base + nops && n < 40000) begin
      @(posedge clk); #1;
      v16 = ($urandom_range(0, 3) != 0);
      a16 = rnd16(); b16 = rnd16(); sub16 = 1'($urandom);
      ordy16 = ($urandom_range(0, 3) != 0);
      n++;
    end
    v16 = 1'b0;
    ordy16 = 1'b1;
    n = 0;
    while (!(r16 && q16.size() == 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rand16_count", 65'(acc16 - base), 65'(nops));
    chk("drain16", 65'(q16.size()), 65'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    v64 = 0; sub64 = 0; a64 = '0; b64 = '0; ordy64 = 1;
    v16 = 0; sub16 = 0; a16 = '0; b16 = '0; ordy16 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset64", {r64, ov64, c64, busy64, s64[60:0]}, {1'b1, 64'h0});
    chk("reset64_sum", 65'(s64), 65'(0));
    chk("reset16", 65'({r16, ov16, c16, busy16, s16}), 65'({1'b1, 19'h0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full carry ripple across every segment.
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_idle64();
    chk("add_carry_chain", {c64, s64}, {1'b1, 64'h0});

    // Borrow across a segment boundary, then borrow out of the top.
    op64(64'h0000_0000_0001_0000, 64'h1, 1'b1);
    wait_idle64();
    chk("sub_seg_borrow", {c64, s64}, {1'b1, 64'h0000_0000_0000_FFFF});
    op64(64'h0, 64'h1, 1'b1);
    wait_idle64();
    chk("sub_underflow", {c64, s64}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

    // Back-pressure in DONE.
    ordy64 = 1'b0;
    op64(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0);
    for (int i = 0; i < 20 && !ov64; i++) begin
      @(posedge clk); #1;
    end
    chk("done_reached", 65'(ov64), 65'(1));
    repeat (5) begin
      @(posedge clk); #1;
      chk("done_in_ready", 65'({r64, busy64, ov64}), 65'(3'b011));
    end
    ordy64 = 1'b1;
    @(posedge clk); #1;
    chk("done_release", 65'({r64, busy64, ov64}), 65'(3'b100));
    chk("done_value", {c64, s64}, {1'b1, 64'h0000_0000_0000_0002});

    // Reset in the middle of a run discards the op.
    op64(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_reset", {r64, ov64, c64, busy64, s64[60:0]}, {1'b1, 64'h0});
    chk("midrun_reset_sum", 65'(s64), 65'(0));
    q64.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op64(64'h1234, 64'h1, 1'b0);
    wait_idle64();
    chk("after_reset", {c64, s64}, {1'b0, 64'h1235});

    // in_valid held high with changing operands: one accept per NSEG+2 cycles.
    a0 = acc64;
    v64 = 1'b1; a64 = rnd64(); b64 = rnd64(); sub64 = 1'($urandom);
    repeat (18) begin
      @(posedge clk); #1;
      a64 = rnd64(); b64 = rnd64(); sub64 = 1'($urandom);
    end
    v64 = 1'b0;
    chk("stream_accepts", 65'(acc64 - a0), 65'(3));
    wait_idle64();

    fork
      rand64(1000);
      rand16(1000);
    join

    chk("drain64", 65'(q64.size()), 65'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
